// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between two requester ports.
// Each access runs as SETUP -> ACCESS (WAIT_CYCLES) -> HOLD with registered
// strobes. Ties are resolved round-robin by default. Defining
// SRAM_ARB_FIXED_PRIO_EN makes port 0 win every tie instead.
module sram_arbiter #(
  parameter int AW          = 19,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic [DW-1:0] rdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata1,
  output logic          ack1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_dat_out,
  output logic          ram_dat_oe,
  input  logic [DW-1:0] ram_dat_in,
  output logic          ram_cs_n,
  output logic          ram_oe_n,
  output logic          ram_we_n,
  output logic          busy
);

  // The strobe counter is 4 bits wide, so only 1..15 strobe cycles fit.
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_arbiter: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          grant_q, grant_d;
  logic          wr_q, wr_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic          last_q, last_d;
`endif
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic          dat_oe_q, dat_oe_d, busy_q, busy_d;
  logic          pick;

  // Next-state, arbitration and registered-output decode; the strobes are
  // derived from the next state so they line up with the state register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    wr_d     = wr_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    addr_d   = addr_q;
    dout_d   = dout_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    pick     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            pick = 1'b0;
`else
            pick = ~last_q;
`endif
          end else begin
            pick = req1;
          end
          grant_d = pick;
          wr_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          if (wr_d) begin
            dout_d = pick ? wdata1 : wdata0;
          end
`ifndef SRAM_ARB_FIXED_PRIO_EN
          last_d  = pick;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          if (!wr_q) begin
            if (grant_q) begin
              rdata1_d = ram_dat_in;
            end else begin
              rdata0_d = ram_dat_in;
            end
          end
          ack0_d = ~grant_q;
          ack1_d = grant_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cs_n_d   = (state_d == IDLE);
    oe_n_d   = !(!wr_d && (state_d == SETUP || state_d == ACCESS));
    we_n_d   = !(wr_d && state_d == ACCESS);
    dat_oe_d = wr_d && (state_d != IDLE);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      grant_q  <= 1'b0;
      wr_q     <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
      addr_q   <= '0;
      dout_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      cs_n_q   <= cs_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
    end
  end

  assign ram_addr    = addr_q;
  assign ram_dat_out = dout_q;
  assign ram_dat_oe  = dat_oe_q;
  assign ram_cs_n    = cs_n_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus a random requester run against a
// behavioural asynchronous SRAM model.
module tb_sram_arbiter;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam int WAIT_CYCLES = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
  logic          ack0, ack1;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramDatOut, ramDatIn;
  logic          ramDatOe, ramCsN, ramOeN, ramWeN, busy;

  int assertCount = 0;
  int failCount = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // 100 MHz clock
  always #5 clk = ~clk;

  // SRAM read path: data driven while selected and output-enabled
  assign ramDatIn = (ramCsN === 1'b0 && ramOeN === 1'b0) ? mem[ramAddr] : '0;

  // SRAM write commits on the rising edge of WE while still selected
  always @(posedge ramWeN) begin
    if (ramCsN === 1'b0) mem[ramAddr] = ramDatOut;
  end

  sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
    .ram_addr(ramAddr), .ram_dat_out(ramDatOut), .ram_dat_oe(ramDatOe), .ram_dat_in(ramDatIn),
    .ram_cs_n(ramCsN), .ram_oe_n(ramOeN), .ram_we_n(ramWeN), .busy(busy)
  );

  // Reset state of every output
  task automatic test_reset();
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    assertCount++; if (ramCsN !== 1'b1) begin failCount++; $display("[TB] FAIL reset_cs_n got=%b exp=1", ramCsN); end
    assertCount++; if (ramOeN !== 1'b1) begin failCount++; $display("[TB] FAIL reset_oe_n got=%b exp=1", ramOeN); end
    assertCount++; if (ramWeN !== 1'b1) begin failCount++; $display("[TB] FAIL reset_we_n got=%b exp=1", ramWeN); end
    assertCount++; if (ramDatOe !== 1'b0) begin failCount++; $display("[TB] FAIL reset_dat_oe got=%b exp=0", ramDatOe); end
    assertCount++; if (ramAddr !== '0) begin failCount++; $display("[TB] FAIL reset_addr got=%h exp=0", ramAddr); end
    assertCount++; if (ramDatOut !== '0) begin failCount++; $display("[TB] FAIL reset_dat_out got=%h exp=0", ramDatOut); end
    assertCount++; if (rdata0 !== '0 || rdata1 !== '0) begin failCount++; $display("[TB] FAIL reset_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
    assertCount++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ack got=%b/%b exp=0/0", ack0, ack1); end
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
  endtask

  // Port 0 write: strobe widths and ack latency
  task automatic test_write();
    int csLow = 0, weLow = 0, weFirst = -1, oeCnt = 0, rdOe = 0, ackCnt = 0, ackCycle = -1, ack1Cnt = 0;
    logic [AW-1:0] addrSeen = '0;
    logic [DW-1:0] doutSeen = '0;
    req0 = 1; we0 = 1; addr0 = 19'h00012; wdata0 = 16'hBEEF;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (!ramCsN) csLow++;
      if (!ramWeN) begin weLow++; if (weFirst < 0) weFirst = k; end
      if (ramDatOe) oeCnt++;
      if (!ramOeN) rdOe++;
      if (k == 3) begin addrSeen = ramAddr; doutSeen = ramDatOut; end
      if (ack1) ack1Cnt++;
      if (ack0) begin ackCnt++; ackCycle = k; req0 = 0; end
    end
    assertCount++; if (csLow != 4) begin failCount++; $display("[TB] FAIL wr_cs_low got=%0d exp=4", csLow); end
    assertCount++; if (weLow != 2) begin failCount++; $display("[TB] FAIL wr_we_low got=%0d exp=2", weLow); end
    assertCount++; if (weFirst != 2) begin failCount++; $display("[TB] FAIL wr_we_first got=%0d exp=2", weFirst); end
    assertCount++; if (oeCnt != 4) begin failCount++; $display("[TB] FAIL wr_dat_oe got=%0d exp=4", oeCnt); end
    assertCount++; if (rdOe != 0) begin failCount++; $display("[TB] FAIL wr_oe_low got=%0d exp=0", rdOe); end
    assertCount++; if (ackCnt != 1 || ackCycle != 4) begin failCount++; $display("[TB] FAIL wr_ack0 got=%0d@%0d exp=1@4", ackCnt, ackCycle); end
    assertCount++; if (ack1Cnt != 0) begin failCount++; $display("[TB] FAIL wr_ack1 got=%0d exp=0", ack1Cnt); end
    assertCount++; if (addrSeen !== 19'h00012 || doutSeen !== 16'hBEEF) begin failCount++; $display("[TB] FAIL wr_bus got=%h/%h exp=00012/beef", addrSeen, doutSeen); end
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL wr_busy_after got=%b exp=0", busy); end
    assertCount++; if (mem[19'h00012] !== 16'hBEEF) begin failCount++; $display("[TB] FAIL wr_mem got=%h exp=beef", mem[19'h00012]); end
  endtask

  // Port 1 read of the word just written
  task automatic test_read();
    int oeLow = 0, datOe = 0, weLow = 0, ack1Cnt = 0, ack1Cycle = -1, ack0Cnt = 0;
    logic [DW-1:0] rdSeen = '0;
    req1 = 1; we1 = 0; addr1 = 19'h00012;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (!ramOeN) oeLow++;
      if (ramDatOe) datOe++;
      if (!ramWeN) weLow++;
      if (ack0) ack0Cnt++;
      if (ack1) begin ack1Cnt++; ack1Cycle = k; rdSeen = rdata1; req1 = 0; end
    end
    assertCount++; if (oeLow != 3) begin failCount++; $display("[TB] FAIL rd_oe_low got=%0d exp=3", oeLow); end
    assertCount++; if (datOe != 0) begin failCount++; $display("[TB] FAIL rd_dat_oe got=%0d exp=0", datOe); end
    assertCount++; if (weLow != 0) begin failCount++; $display("[TB] FAIL rd_we_low got=%0d exp=0", weLow); end
    assertCount++; if (ack1Cnt != 1 || ack1Cycle != 4) begin failCount++; $display("[TB] FAIL rd_ack1 got=%0d@%0d exp=1@4", ack1Cnt, ack1Cycle); end
    assertCount++; if (rdSeen !== 16'hBEEF) begin failCount++; $display("[TB] FAIL rd_rdata1 got=%h exp=beef", rdSeen); end
    assertCount++; if (rdata1 !== 16'hBEEF) begin failCount++; $display("[TB] FAIL rd_rdata1_held got=%h exp=beef", rdata1); end
    assertCount++; if (rdata0 !== 16'h0000) begin failCount++; $display("[TB] FAIL rd_rdata0 got=%h exp=0000", rdata0); end
    assertCount++; if (ack0Cnt != 0) begin failCount++; $display("[TB] FAIL rd_ack0 got=%0d exp=0", ack0Cnt); end
  endtask

  // Both ports requesting continuously for four accesses
  task automatic test_round_robin();
    int n = 0, both = 0;
    int grants [4];
    int cycles [4];
    int expGrant [4];
`ifdef SRAM_ARB_FIXED_PRIO_EN
    expGrant = '{0, 0, 0, 0};
`else
    expGrant = '{0, 1, 0, 1};
`endif
    grants = '{-1, -1, -1, -1};
    cycles = '{-1, -1, -1, -1};
    req0 = 1; we0 = 0; addr0 = 19'h00012;
    req1 = 1; we1 = 0; addr1 = 19'h00012;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (ack0 && ack1) both++;
      if (ack0 || ack1) begin
        if (n < 4) begin grants[n] = ack1 ? 1 : 0; cycles[n] = k; end
        n++;
        if (n == 4) begin req0 = 0; req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    assertCount++; if (n != 4) begin failCount++; $display("[TB] FAIL rr_count got=%0d exp=4", n); end
    assertCount++; if (both != 0) begin failCount++; $display("[TB] FAIL rr_both_ack got=%0d exp=0", both); end
    for (int i = 0; i < 4; i++) begin
      assertCount++; if (grants[i] != expGrant[i]) begin failCount++; $display("[TB] FAIL rr_grant%0d got=%0d exp=%0d", i, grants[i], expGrant[i]); end
      assertCount++; if (cycles[i] != 4 + 5 * i) begin failCount++; $display("[TB] FAIL rr_cycle%0d got=%0d exp=%0d", i, cycles[i], 4 + 5 * i); end
    end
  endtask

  // Port 1 requests while port 0 is mid-strobe
  task automatic test_late_request();
    int weLow = 0, ack0Cycle = -1, ack1Cycle = -1;
    logic [DW-1:0] rdSeen = '0;
    req0 = 1; we0 = 1; addr0 = 19'h00100; wdata0 = 16'h1234;
    we1 = 0; addr1 = 19'h00100;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (!ramWeN) weLow++;
      if (ack0) begin ack0Cycle = k; req0 = 0; end
      if (ack1) begin ack1Cycle = k; rdSeen = rdata1; req1 = 0; end
      if (k == 2) req1 = 1;
    end
    assertCount++; if (weLow != 2) begin failCount++; $display("[TB] FAIL late_we_low got=%0d exp=2", weLow); end
    assertCount++; if (ack0Cycle != 4) begin failCount++; $display("[TB] FAIL late_ack0 got=%0d exp=4", ack0Cycle); end
    assertCount++; if (ack1Cycle != 9) begin failCount++; $display("[TB] FAIL late_ack1 got=%0d exp=9", ack1Cycle); end
    assertCount++; if (rdSeen !== 16'h1234) begin failCount++; $display("[TB] FAIL late_rdata1 got=%h exp=1234", rdSeen); end
  endtask

  // Reset during a write strobe, then a tie straight after reset
  task automatic test_reset_mid_access();
    int ack0Cnt = 0, firstPort = -1, firstCycle = -1;
    req0 = 1; we0 = 1; addr0 = 19'h00200; wdata0 = 16'h5555;
    req1 = 0;
    repeat (2) @(negedge clk);
    assertCount++; if (ramWeN !== 1'b0) begin failCount++; $display("[TB] FAIL rst_pre_we_n got=%b exp=0", ramWeN); end
    rst = 1'b1;
    @(negedge clk);
    assertCount++; if (ramWeN !== 1'b1) begin failCount++; $display("[TB] FAIL rst_we_n got=%b exp=1", ramWeN); end
    assertCount++; if (ramCsN !== 1'b1) begin failCount++; $display("[TB] FAIL rst_cs_n got=%b exp=1", ramCsN); end
    assertCount++; if (ramDatOe !== 1'b0) begin failCount++; $display("[TB] FAIL rst_dat_oe got=%b exp=0", ramDatOe); end
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
    if (ack0) ack0Cnt++;
    rst = 1'b0; req0 = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0) ack0Cnt++;
    end
    assertCount++; if (ack0Cnt != 0) begin failCount++; $display("[TB] FAIL rst_no_ack0 got=%0d exp=0", ack0Cnt); end
    req0 = 1; we0 = 0; addr0 = 19'h00012;
    req1 = 1; we1 = 0; addr1 = 19'h00012;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if ((ack0 || ack1) && firstPort < 0) begin
        firstPort = ack1 ? 1 : 0; firstCycle = k; req0 = 0; req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    assertCount++; if (firstPort != 0 || firstCycle != 4) begin failCount++; $display("[TB] FAIL rst_tie got=port%0d@%0d exp=port0@4", firstPort, firstCycle); end
    repeat (6) @(negedge clk);
  endtask

  // Random requesters with invariant checks and a write scoreboard
  task automatic test_random();
    logic [DW-1:0] sb [logic [AW-1:0]];
    logic [DW-1:0] expData;
    logic skip0, skip1;
    req0 = 0; req1 = 0;
    for (int c = 0; c < 1060; c++) begin
      @(negedge clk);
      assertCount++; if (!ramWeN && !ramOeN) begin failCount++; $display("[TB] FAIL rand_we_oe cycle=%0d got=both_low exp=not_both", c); end
      assertCount++; if (ack0 && ack1) begin failCount++; $display("[TB] FAIL rand_acks cycle=%0d got=both exp=one", c); end
      assertCount++; if (ramDatOe && !ramOeN) begin failCount++; $display("[TB] FAIL rand_oe_read cycle=%0d got=dat_oe_in_read exp=none", c); end
      skip0 = 0; skip1 = 0;
      if (ack0) begin
        if (we0) sb[addr0] = wdata0;
        else begin
          expData = sb.exists(addr0) ? sb[addr0] : 16'h0000;
          assertCount++; if (rdata0 !== expData) begin failCount++; $display("[TB] FAIL rand_rdata0 addr=%h got=%h exp=%h", addr0, rdata0, expData); end
        end
        req0 = 0; skip0 = 1;
      end
      if (ack1) begin
        if (we1) sb[addr1] = wdata1;
        else begin
          expData = sb.exists(addr1) ? sb[addr1] : 16'h0000;
          assertCount++; if (rdata1 !== expData) begin failCount++; $display("[TB] FAIL rand_rdata1 addr=%h got=%h exp=%h", addr1, rdata1, expData); end
        end
        req1 = 0; skip1 = 1;
      end
      if (c < 1000 && !req0 && !skip0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; we0 = 1'($urandom_range(0, 1));
        addr0 = 19'h40000 + 19'($urandom_range(0, 31)); wdata0 = 16'($urandom);
      end
      if (c < 1000 && !req1 && !skip1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; we1 = 1'($urandom_range(0, 1));
        addr1 = 19'h40000 + 19'($urandom_range(0, 31)); wdata1 = 16'($urandom);
      end
    end
    assertCount++; if (req0 || req1) begin failCount++; $display("[TB] FAIL rand_drain got=%b%b exp=00", req0, req1); end
    assertCount++; if (sb.num() == 0) begin failCount++; $display("[TB] FAIL rand_writes got=0 exp=nonzero"); end
    foreach (sb[a]) begin
      assertCount++; if (mem[a] !== sb[a]) begin failCount++; $display("[TB] FAIL rand_mem addr=%h got=%h exp=%h", a, mem[a], sb[a]); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    $display("[TB] starting sram_arbiter bench");
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_late_request();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
